// File: rtl/ofdm_pkg.sv
// Shared constants and FSM state type for the OFDM receive datapath.
package ofdm_pkg;
    localparam int N_FFT    = 64;
    localparam int CP_LEN   = 16;
    localparam int SAMPLE_W = 32;

    typedef enum logic [1:0] {IDLE, CP, DATA, DRAIN} state_e;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/fft_sym_ctrl_wb_out_stage.sv
// One-entry Wishbone-style output register: holds data/strobe until the sink acks.
module wb_out_stage #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_dat,
    input  logic         i_tag,
    input  logic         i_ack,
    output logic [W-1:0] o_dat,
    output logic         o_stb,
    output logic         o_tag,
    output logic         o_rdy
);
    logic [W-1:0] r_dat;
    logic         r_stb;
    logic         r_tag;

    // Free to take a new entry unless the current one is still waiting for its ack.
    assign o_rdy = ~(r_stb & ~i_ack);
    assign o_dat = r_dat;
    assign o_stb = r_stb;
    assign o_tag = r_tag;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dat <= '0;
            r_stb <= 1'b0;
            r_tag <= 1'b0;
        end else if (i_load) begin
            r_dat <= i_dat;
            r_stb <= 1'b1;
            r_tag <= i_tag;
        end else if (o_rdy) begin
            r_stb <= 1'b0;
            r_tag <= 1'b0;
        end
    end
endmodule

// File: rtl/fft_sym_ctrl.sv
// Strips the cyclic prefix from each OFDM symbol and forwards N_FFT samples per
// symbol to the FFT over a Wishbone-style master port, framing whole packets.
module fft_sym_ctrl #(
    parameter int N_FFT  = ofdm_pkg::N_FFT,
    parameter int CP_LEN = ofdm_pkg::CP_LEN,
    parameter int SYM_W  = 10
) (
    input  logic                          CLK_I,
    input  logic                          RST_I,
    input  logic [SYM_W-1:0]              NSYM_I,
    input  logic [ofdm_pkg::SAMPLE_W-1:0] DAT_I,
    input  logic                          WE_I,
    input  logic                          STB_I,
    input  logic                          CYC_I,
    output logic                          ACK_O,
    output logic [ofdm_pkg::SAMPLE_W-1:0] DAT_O,
    output logic                          CYC_O,
    output logic                          STB_O,
    output logic                          WE_O,
    input  logic                          ACK_I,
    output logic                          SYM_DONE_O,
    output logic                          BUSY_O
);
    import ofdm_pkg::*;

    localparam int                CNT_W     = cnt_width(N_FFT, CP_LEN);
    localparam logic [CNT_W-1:0]  CP_LAST   = CNT_W'(CP_LEN - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(N_FFT - 1);
    localparam state_e            SYM_START = (CP_LEN > 0) ? CP : DATA;

    state_e             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [SYM_W-1:0]   r_sym, w_sym_next, w_sym_inc;
    logic [SYM_W-1:0]   r_nsym, w_nsym_next;
    logic               r_cyc_o, w_cyc_o_next;
    logic               r_cyc_d;
    logic               r_sym_done;

    logic               w_in_v, w_start, w_ack, w_load, w_tag;
    logic               w_stb, w_out_tag, w_rdy;

    assign w_in_v    = CYC_I & STB_I & WE_I;
    // Edge-qualified so a CYC_I left high after a packet cannot restart one.
    assign w_start   = CYC_I & ~r_cyc_d;
    assign w_sym_inc = r_sym + SYM_W'(1);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sym_next   = r_sym;
        w_nsym_next  = r_nsym;
        w_cyc_o_next = r_cyc_o;
        w_ack        = 1'b0;
        w_load       = 1'b0;
        w_tag        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_nsym_next  = (NSYM_I == '0) ? SYM_W'(1) : NSYM_I;
                    w_cnt_next   = '0;
                    w_sym_next   = '0;
                    w_cyc_o_next = 1'b1;
                    w_state_next = SYM_START;
                end
            end
            CP: begin
                if (!CYC_I) begin
                    w_state_next = DRAIN;
                end else if (w_in_v) begin
                    w_ack = 1'b1;
                    if (r_cnt == CP_LAST) begin
                        w_cnt_next   = '0;
                        w_state_next = DATA;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (!CYC_I) begin
                    w_state_next = DRAIN;
                end else if (w_in_v && w_rdy) begin
                    w_ack  = 1'b1;
                    w_load = 1'b1;
                    w_tag  = (r_cnt == DATA_LAST);
                    if (r_cnt == DATA_LAST) begin
                        w_cnt_next   = '0;
                        w_sym_next   = w_sym_inc;
                        w_state_next = (w_sym_inc == r_nsym) ? DRAIN : SYM_START;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!w_stb || ACK_I) begin
                    w_cyc_o_next = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sym      <= '0;
            r_nsym     <= '0;
            r_cyc_o    <= 1'b0;
            r_cyc_d    <= 1'b0;
            r_sym_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_sym      <= w_sym_next;
            r_nsym     <= w_nsym_next;
            r_cyc_o    <= w_cyc_o_next;
            r_cyc_d    <= CYC_I;
            r_sym_done <= w_stb & ACK_I & w_out_tag;
        end
    end

    wb_out_stage #(
        .W (SAMPLE_W)
    ) u_out (
        .i_clk   (CLK_I),
        .i_rst_n (RST_I),
        .i_load  (w_load),
        .i_dat   (DAT_I),
        .i_tag   (w_tag),
        .i_ack   (ACK_I),
        .o_dat   (DAT_O),
        .o_stb   (w_stb),
        .o_tag   (w_out_tag),
        .o_rdy   (w_rdy)
    );

    assign ACK_O      = w_ack;
    assign STB_O      = w_stb;
    assign WE_O       = w_stb;
    assign CYC_O      = r_cyc_o;
    assign SYM_DONE_O = r_sym_done;
    assign BUSY_O     = (r_state != IDLE);
endmodule

// File: tb/tb_fft_sym_ctrl.sv
// Directed bench for fft_sym_ctrl: source of indexed samples, FFT-side sink with
// configurable ack patterns, and per-scenario checks against hand-derived sequences.
`timescale 1ns/1ps
module tb_fft_sym_ctrl;
    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic [9:0]  NSYM_I = '0;
    logic [31:0] DAT_I = '0;
    logic        WE_I = 1'b0, STB_I = 1'b0, CYC_I = 1'b0, ACK_I = 1'b0;
    logic        ACK_O, CYC_O, STB_O, WE_O, SYM_DONE_O, BUSY_O;
    logic [31:0] DAT_O;

    always #5 CLK_I = ~CLK_I;

    fft_sym_ctrl #(.N_FFT(64), .CP_LEN(16), .SYM_W(10)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .NSYM_I(NSYM_I), .DAT_I(DAT_I),
        .WE_I(WE_I), .STB_I(STB_I), .CYC_I(CYC_I), .ACK_O(ACK_O),
        .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
        .ACK_I(ACK_I), .SYM_DONE_O(SYM_DONE_O), .BUSY_O(BUSY_O)
    );

    int total = 0;
    int bad   = 0;

    int src_idx, src_limit, cyc_n, pkt_c, ack_mode, abort_at;
    int last_hs_cyc, cyc_fall_cyc, last_sd_cyc, sd_cnt, viol, snap_src, snap_outn;
    logic s_ack, s_stb, s_cyc, s_busy, s_sd, prev_cyc, timed_out;
    logic [31:0] s_dat;
    logic [31:0] outq[$];

    // Symbol k of the output carries source indices 80*sym+16 .. 80*sym+79.
    function automatic logic [31:0] exp_data(input int k);
        return 32'((k / 64) * 80 + 16 + (k % 64));
    endfunction

    function automatic int seq_errs();
        int e = 0;
        foreach (outq[k]) if (outq[k] !== exp_data(k)) e++;
        return e;
    endfunction

    // One clock: drive at posedge+1, observe at negedge, account after next posedge.
    task automatic tick();
        if (pkt_c == 20) begin
            snap_src  = src_idx;
            snap_outn = outq.size();
        end
        if (abort_at >= 0 && src_idx >= abort_at) CYC_I = 1'b0;
        case (ack_mode)
            1:       ACK_I = (pkt_c % 2 == 0);
            2:       ACK_I = (pkt_c >= 20);
            default: ACK_I = 1'b1;
        endcase
        STB_I = CYC_I && (src_idx < src_limit);
        WE_I  = STB_I;
        DAT_I = 32'(src_idx);
        #4;
        s_ack  = ACK_O;
        s_stb  = STB_O;
        s_dat  = DAT_O;
        s_cyc  = CYC_O;
        s_busy = BUSY_O;
        s_sd   = SYM_DONE_O;
        if (s_sd) begin
            sd_cnt++;
            last_sd_cyc = cyc_n;
        end
        if (s_ack && s_stb && !ACK_I && (src_idx % 80) >= 16) viol++;
        if (s_stb && ACK_I) begin
            outq.push_back(s_dat);
            last_hs_cyc = cyc_n;
        end
        if (prev_cyc && !s_cyc) cyc_fall_cyc = cyc_n;
        prev_cyc = s_cyc;
        @(posedge CLK_I);
        #1;
        if (s_ack) src_idx++;
        cyc_n++;
        pkt_c++;
    endtask

    task automatic run_packet(input int nsym, input int nsrc, input int mode,
                              input int ab, input int stop_out);
        logic started;
        abort_at = -1;
        CYC_I    = 1'b0;
        tick();
        tick();
        NSYM_I    = 10'(nsym);
        src_idx   = 0;
        src_limit = nsrc;
        ack_mode  = mode;
        abort_at  = ab;
        outq.delete();
        sd_cnt = 0; viol = 0; pkt_c = 0;
        last_hs_cyc = -1; cyc_fall_cyc = -1; last_sd_cyc = -1;
        snap_src = -1; snap_outn = -1;
        CYC_I     = 1'b1;
        started   = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (stop_out > 0 && outq.size() >= stop_out) begin
                timed_out = 1'b0;
                break;
            end
            if (s_busy) started = 1'b1;
            else if (started) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST_I = 1'b0;
        repeat (3) @(posedge CLK_I);
        #1;
        total++;
        if ({CYC_O, STB_O, WE_O, SYM_DONE_O, BUSY_O, ACK_O} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000000", {CYC_O, STB_O, WE_O, SYM_DONE_O, BUSY_O, ACK_O});
        end
        total++;
        if (DAT_O !== 32'h0) begin
            bad++;
            $display("FAIL reset_dat got=%h want=0", DAT_O);
        end
        RST_I = 1'b1;
        prev_cyc = 1'b0;
        cyc_n = 0;
    endtask

    task automatic test_basic();
        int busy_seen = 0;
        run_packet(2, 160, 0, -1, 0);
        total++;
        if (timed_out !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b want=0", timed_out); end
        total++;
        if (outq.size() != 128) begin bad++; $display("FAIL basic_count got=%0d want=128", outq.size()); end
        total++;
        if (seq_errs() != 0) begin bad++; $display("FAIL basic_seq errors=%0d want=0", seq_errs()); end
        total++;
        if (sd_cnt != 2) begin bad++; $display("FAIL basic_symdone got=%0d want=2", sd_cnt); end
        total++;
        if (cyc_fall_cyc - last_hs_cyc != 1) begin
            bad++;
            $display("FAIL basic_cyc_fall got=%0d want=1", cyc_fall_cyc - last_hs_cyc);
        end
        total++;
        if (last_sd_cyc - last_hs_cyc != 1) begin
            bad++;
            $display("FAIL basic_symdone_timing got=%0d want=1", last_sd_cyc - last_hs_cyc);
        end
        src_limit = 1000;
        repeat (5) begin
            tick();
            if (s_busy) busy_seen++;
        end
        total++;
        if (busy_seen != 0) begin bad++; $display("FAIL held_cyc_restart busy_cycles=%0d want=0", busy_seen); end
        $display("packet basic: outputs=%0d symdone=%0d", outq.size(), sd_cnt);
    endtask

    task automatic test_ack_toggle();
        run_packet(2, 160, 1, -1, 0);
        total++;
        if (outq.size() != 128) begin bad++; $display("FAIL toggle_count got=%0d want=128", outq.size()); end
        total++;
        if (seq_errs() != 0) begin bad++; $display("FAIL toggle_seq errors=%0d want=0", seq_errs()); end
        total++;
        if (viol != 0) begin bad++; $display("FAIL toggle_ack_in_stall got=%0d want=0", viol); end
        total++;
        if (sd_cnt != 2) begin bad++; $display("FAIL toggle_symdone got=%0d want=2", sd_cnt); end
        $display("packet toggle: outputs=%0d stall_acks=%0d", outq.size(), viol);
    endtask

    task automatic test_cp_stall();
        run_packet(1, 80, 2, -1, 0);
        total++;
        if (snap_src != 17) begin bad++; $display("FAIL stall_src_acked got=%0d want=17", snap_src); end
        total++;
        if (snap_outn != 0) begin bad++; $display("FAIL stall_no_output got=%0d want=0", snap_outn); end
        total++;
        if (outq.size() != 64 || seq_errs() != 0) begin
            bad++;
            $display("FAIL stall_seq count=%0d errors=%0d want=64/0", outq.size(), seq_errs());
        end
        $display("packet cp_stall: acked_at_resume=%0d outputs=%0d", snap_src, outq.size());
    endtask

    task automatic test_nsym_zero();
        run_packet(0, 160, 0, -1, 0);
        total++;
        if (outq.size() != 64 || seq_errs() != 0) begin
            bad++;
            $display("FAIL nsym0_seq count=%0d errors=%0d want=64/0", outq.size(), seq_errs());
        end
        total++;
        if (src_idx != 80) begin bad++; $display("FAIL nsym0_consumed got=%0d want=80", src_idx); end
        total++;
        if (s_busy !== 1'b0 || timed_out !== 1'b0) begin
            bad++;
            $display("FAIL nsym0_idle busy=%b timeout=%b want=0/0", s_busy, timed_out);
        end
        $display("packet nsym0: outputs=%0d consumed=%0d", outq.size(), src_idx);
    endtask

    task automatic test_abort();
        run_packet(2, 160, 1, 46, 0);
        total++;
        if (outq.size() != 30 || seq_errs() != 0) begin
            bad++;
            $display("FAIL abort_seq count=%0d errors=%0d want=30/0", outq.size(), seq_errs());
        end
        total++;
        if (s_cyc !== 1'b0 || s_busy !== 1'b0 || timed_out !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle cyc=%b busy=%b timeout=%b want=0/0/0", s_cyc, s_busy, timed_out);
        end
        $display("packet abort: outputs=%0d", outq.size());
        run_packet(1, 80, 0, -1, 0);
        total++;
        if (outq.size() != 64 || seq_errs() != 0) begin
            bad++;
            $display("FAIL abort_next_seq count=%0d errors=%0d want=64/0", outq.size(), seq_errs());
        end
        $display("packet after_abort: outputs=%0d", outq.size());
    endtask

    task automatic test_async_reset();
        run_packet(2, 160, 0, -1, 5);
        total++;
        if (STB_O !== 1'b1 || CYC_O !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre stb=%b cyc=%b want=1/1", STB_O, CYC_O);
        end
        #2;
        RST_I = 1'b0;
        #1;
        total++;
        if ({CYC_O, STB_O, WE_O, SYM_DONE_O, BUSY_O, ACK_O} !== 6'b0) begin
            bad++;
            $display("FAIL areset_ctrl got=%b want=000000", {CYC_O, STB_O, WE_O, SYM_DONE_O, BUSY_O, ACK_O});
        end
        total++;
        if (DAT_O !== 32'h0) begin bad++; $display("FAIL areset_dat got=%h want=0", DAT_O); end
        CYC_I = 1'b0;
        #3;
        RST_I = 1'b1;
        @(posedge CLK_I);
        #1;
        prev_cyc = 1'b0;
        run_packet(1, 80, 0, -1, 0);
        total++;
        if (outq.size() != 64 || seq_errs() != 0) begin
            bad++;
            $display("FAIL areset_resume count=%0d errors=%0d want=64/0", outq.size(), seq_errs());
        end
        $display("packet after_reset: outputs=%0d", outq.size());
    endtask

    initial begin
        ack_mode = 0; abort_at = -1; src_idx = 0; src_limit = 0; pkt_c = 0; cyc_n = 0;
        prev_cyc = 1'b0;
        test_reset();
        test_basic();
        test_ack_toggle();
        test_cp_stall();
        test_nsym_zero();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
